decoder_nto2n_seq: RTL and testbench

DECODER_NTO2N_SEQ -- requirements
Module: decoder_nto2n_seq

---
 rtl/decoder_pkg.sv | 20 ++
 rtl/dwell_counter.sv | 35 +++
 rtl/decoder_nto2n_seq.sv | 160 ++++++++++++++++
 tb/tb_decoder_nto2n_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared FSM state encoding and MODE constants for the
//               sequential N-to-2^N decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_HOLD = 2'd1;
    localparam state_t c_ST_SCAN = 2'd2;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dwell_counter.sv
`default_nettype none
// ============================================================================
// Module      : dwell_counter
// Description : Loadable down-counter that times how long the scan stays on
//               one position. Load wins over decrement; it stops at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_dec,
    input  logic [DWELL_W-1:0] i_load_val,
    output logic               o_zero
);

    logic [DWELL_W-1:0] r_count;

    // Reload on a new position, otherwise count down to zero and stay there
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/decoder_nto2n_seq.sv
`default_nettype none
// ============================================================================
// Module      : decoder_nto2n_seq
// Description : Registered N-to-2^N one-hot decoder with a direct mode
//               (select/ready handshake) and an optional scan mode that
//               walks the one-hot bit from 0 to LAST with a programmable
//               dwell per position.
//               Optional feature macro: DECODER_SCAN_EN (scan mode; without
//               it MODE/DWELL/LAST are ignored and WRAP is tied low).
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_nto2n_seq
    import decoder_pkg::*;
#(
    parameter  int SEL_W   = 3,
    parameter  int DWELL_W = 8,
    localparam int NOUT    = 2**SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               sel_valid,
    input  logic [SEL_W-1:0]   sel,
    output logic               sel_ready,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [SEL_W-1:0]   last,
    output logic [NOUT-1:0]    y,
    output logic               y_valid,
    output logic               wrap
);

    localparam logic [NOUT-1:0] c_ONE = NOUT'(1);

    state_t          r_state;
    logic [NOUT-1:0] r_y;
    logic            r_y_valid;
    logic [NOUT-1:0] w_sel_onehot;
    logic            w_accept;

    assign w_sel_onehot = c_ONE << sel;
    assign w_accept     = sel_valid & sel_ready;
    assign y            = r_y;
    assign y_valid      = r_y_valid;

`ifdef DECODER_SCAN_EN

    logic             r_wrap;
    logic [SEL_W-1:0] r_idx;
    logic [SEL_W-1:0] w_idx_next;
    logic             w_scan_mode;
    logic             w_cnt_zero;
    logic             w_scan_start;
    logic             w_scan_adv;
    logic             w_cnt_dec;

    assign w_scan_mode = (mode == MODE_SCAN);
    assign sel_ready   = en & ~rst & ~w_scan_mode;

    // LAST below the current index falls through to the natural modulo wrap
    assign w_idx_next   = (r_idx == last) ? '0 : r_idx + 1'b1;
    assign w_scan_start = en & w_scan_mode & (r_state == c_ST_IDLE);
    assign w_scan_adv   = en & w_scan_mode & (r_state == c_ST_SCAN) & w_cnt_zero;
    assign w_cnt_dec    = en & w_scan_mode & (r_state == c_ST_SCAN) & ~w_cnt_zero;
    assign wrap         = r_wrap;

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_scan_start | w_scan_adv),
        .i_dec      (w_cnt_dec),
        .i_load_val (dwell),
        .o_zero     (w_cnt_zero)
    );

    // Mode FSM: direct handshake in IDLE/HOLD, position stepping in SCAN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_wrap    <= 1'b0;
            r_idx     <= '0;
        end else if (!en) begin
            r_state   <= c_ST_IDLE;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_scan_mode) begin
                        r_state   <= c_ST_SCAN;
                        r_idx     <= '0;
                        r_y       <= c_ONE;
                        r_y_valid <= 1'b1;
                    end else if (w_accept) begin
                        r_state   <= c_ST_HOLD;
                        r_y       <= w_sel_onehot;
                        r_y_valid <= 1'b1;
                    end
                end
                c_ST_HOLD: begin
                    if (w_scan_mode) begin
                        r_state   <= c_ST_IDLE;
                        r_y       <= '0;
                        r_y_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_y       <= w_sel_onehot;
                        r_y_valid <= 1'b1;
                    end
                end
                c_ST_SCAN: begin
                    if (!w_scan_mode) begin
                        r_state   <= c_ST_IDLE;
                        r_y       <= '0;
                        r_y_valid <= 1'b0;
                    end else if (w_cnt_zero) begin
                        r_idx  <= w_idx_next;
                        r_y    <= c_ONE << w_idx_next;
                        r_wrap <= (w_idx_next == '0);
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_y       <= '0;
                    r_y_valid <= 1'b0;
                end
            endcase
        end
    end

`else

    logic w_unused_scan_inputs;

    assign w_unused_scan_inputs = ^{mode, dwell, last};
    assign sel_ready            = en & ~rst;
    assign wrap                 = 1'b0;

    // Direct-only FSM: every accepted select updates the one-hot output
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_state   <= c_ST_IDLE;
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else if (w_accept) begin
            r_state   <= c_ST_HOLD;
            r_y       <= w_sel_onehot;
            r_y_valid <= 1'b1;
        end
    end

`endif

endmodule
`default_nettype wire

// File: tb/tb_decoder_nto2n_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_nto2n_seq
// Description : Self-checking bench for decoder_nto2n_seq. A behavioural
//               model predicts each cycle's outputs into a scoreboard queue;
//               entries are popped and compared after the clock edge.
//               Scan scenarios are exercised when DECODER_SCAN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_nto2n_seq;

    localparam int SEL_W   = 3;
    localparam int DWELL_W = 8;
    localparam int NOUT    = 8;
`ifdef DECODER_SCAN_EN
    localparam bit SCAN_BUILD = 1'b1;
`else
    localparam bit SCAN_BUILD = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               mode;
    logic               sel_valid;
    logic [SEL_W-1:0]   sel;
    logic               sel_ready;
    logic [DWELL_W-1:0] dwell;
    logic [SEL_W-1:0]   last;
    logic [NOUT-1:0]    y;
    logic               y_valid;
    logic               wrap;

    always #5 clk = ~clk;

    decoder_nto2n_seq #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sel_valid (sel_valid),
        .sel       (sel),
        .sel_ready (sel_ready),
        .dwell     (dwell),
        .last      (last),
        .y         (y),
        .y_valid   (y_valid),
        .wrap      (wrap)
    );

    typedef struct packed {
        logic [NOUT-1:0] y;
        logic            yv;
        logic            wrap;
    } exp_t;

    exp_t sb_q[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;

    // Reference model state: position timing counts up to the latched dwell
    int              m_state = 0;   // 0 idle, 1 hold, 2 scan
    logic [NOUT-1:0] m_y     = '0;
    logic            m_yv    = 1'b0;
    logic            m_wrap  = 1'b0;
    int              m_idx   = 0;
    int              m_pos   = 0;
    int              m_dl    = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_state = 0; m_y = '0; m_yv = 1'b0; m_wrap = 1'b0;
            m_idx = 0; m_pos = 0; m_dl = 0;
        end else if (!en) begin
            m_state = 0; m_y = '0; m_yv = 1'b0; m_wrap = 1'b0;
        end else if (SCAN_BUILD && mode) begin
            m_wrap = 1'b0;
            if (m_state == 2) begin
                if (m_pos == m_dl) begin
                    if (m_idx == int'(last) || m_idx == NOUT - 1) begin
                        m_idx  = 0;
                        m_wrap = 1'b1;
                    end else begin
                        m_idx++;
                    end
                    m_pos = 0;
                    m_dl  = int'(dwell);
                    m_y   = '0;
                    m_y[m_idx] = 1'b1;
                end else begin
                    m_pos++;
                end
            end else if (m_state == 1) begin
                m_state = 0; m_y = '0; m_yv = 1'b0;
            end else begin
                m_state = 2; m_idx = 0; m_pos = 0; m_dl = int'(dwell);
                m_y = NOUT'(1); m_yv = 1'b1;
            end
        end else begin
            m_wrap = 1'b0;
            if (m_state == 2) begin
                m_state = 0; m_y = '0; m_yv = 1'b0;
            end else if (sel_valid) begin
                m_y = '0;
                m_y[sel] = 1'b1;
                m_yv = 1'b1;
                m_state = 1;
            end
        end
    endtask

    // One clock: drive, check combinational ready, predict, then compare
    task automatic cycle(input logic r, input logic e, input logic m, input logic sv,
                         input logic [SEL_W-1:0] s, input logic [DWELL_W-1:0] d,
                         input logic [SEL_W-1:0] l);
        exp_t       ex;
        logic       exp_ready;
        rst = r; en = e; mode = m; sel_valid = sv; sel = s; dwell = d; last = l;
        #1;
        exp_ready = e & ~r & (SCAN_BUILD ? ~m : 1'b1);
        check_val("sel_ready", 64'(sel_ready), 64'(exp_ready));
        model_step();
        sb_q.push_back('{y: m_y, yv: m_yv, wrap: m_wrap});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 64'(1), 64'(0));
        end else begin
            ex = sb_q.pop_front();
            check_val("y",       64'(y),       64'(ex.y));
            check_val("y_valid", 64'(y_valid), 64'(ex.yv));
            check_val("wrap",    64'(wrap),    64'(ex.wrap));
            check_val("onehot",  64'($onehot0(y) && (!y_valid || $onehot(y))), 64'(1));
        end
    endtask

    logic [SEL_W-1:0] rnd_sel;
    logic             rnd_mode;

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel_valid = 1'b0;
        sel = '0; dwell = '0; last = '0;
        @(posedge clk);
        #1;

        // Reset dominates an offered select
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 8'd0, 3'd0);
        check_val("rst_y", 64'(y), 64'(0));
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'd0, 3'd0);
        check_val("first_accept", 64'(y), 64'(8'h20));

        // Direct sweep, one select per cycle
        for (int i = 0; i < NOUT; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b1, SEL_W'(i), 8'd0, 3'd0);
            check_val("sweep", 64'(y), 64'(8'h01) << i);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0, 3'd0);
        check_val("hold", 64'(y), 64'(8'h80));
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'd0, 3'd0);
        check_val("en_off_y", 64'(y), 64'(0));
        check_val("en_off_v", 64'(y_valid), 64'(0));

        // Random direct traffic with occasional enable drops
        repeat (40) begin
            rnd_sel = SEL_W'($urandom_range(0, NOUT - 1));
            cycle(1'b0, ($urandom_range(0, 7) != 0), 1'b0, 1'($urandom_range(0, 1)),
                  rnd_sel, 8'd0, 3'd0);
        end

`ifdef DECODER_SCAN_EN
        // Scan DWELL=2 LAST=3
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0);
        for (int j = 0; j < 27; j++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd2, 3'd3);
            check_val("scan_seq", 64'(y), 64'(8'h01) << ((j / 3) % 4));
            check_val("scan_wrap", 64'(wrap), 64'((j % 12 == 0) && (j != 0)));
        end

        // DWELL=0, LAST=7: advance every cycle
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0);
        repeat (20) cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 3'd7);

        // LAST=0: Y stuck at bit 0, periodic WRAP
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0);
        repeat (16) cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd3, 3'd0);
        check_val("last0_y", 64'(y), 64'(8'h01));

        // MODE 1->0 at index 2, then a direct select
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0);
        repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 3'd7);
        check_val("idx2", 64'(y), 64'(8'h04));
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 3'd7);
        check_val("mode_chg_y", 64'(y), 64'(0));
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 3'd6, 8'd0, 3'd7);
        check_val("after_mode_y", 64'(y), 64'(8'h40));

        // Reset in the middle of a scan
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 3'd0);
        repeat (7) cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd1, 3'd3);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'd1, 3'd3);
        check_val("rst_scan_y", 64'(y), 64'(0));
        check_val("rst_scan_wrap", 64'(wrap), 64'(0));

        // LAST dropped below the current index
        repeat (6) cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 3'd7);
        repeat (8) cycle(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 3'd2);

        // Random mix with rare mode flips and changing dwell/last
        rnd_mode = 1'b1;
        repeat (120) begin
            if ($urandom_range(0, 15) == 0) rnd_mode = ~rnd_mode;
            rnd_sel = SEL_W'($urandom_range(0, NOUT - 1));
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) != 0), rnd_mode,
                  1'($urandom_range(0, 1)), rnd_sel, 8'($urandom_range(0, 3)),
                  SEL_W'($urandom_range(0, NOUT - 1)));
        end
`else
        // Scan inputs have no effect in this build
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 8'd5, 3'd2);
        check_val("noscan_y", 64'(y), 64'(8'h08));
        check_val("noscan_wrap", 64'(wrap), 64'(0));
        repeat (20) begin
            rnd_sel = SEL_W'($urandom_range(0, NOUT - 1));
            cycle(1'b0, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), rnd_sel, 8'($urandom_range(0, 3)),
                  SEL_W'($urandom_range(0, NOUT - 1)));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
